bcp_imp_queue: RTL
==================

# bcp_imp_queue

Implication queue for the BCP processing element. It accepts implied literals (variable, value, thread) from the unit-clause check stage and filters them against a per-thread assignment table. Duplicates are dropped; a contradiction raises a sticky conflict. New literals are buffered in a FIFO that feeds the traversal engine, which is the queue's direct downstream consumer.

## Interface
Parameters:
- VAR_BITS, 6, variable index width; table holds 2·2^VAR_BITS entries (indexed {thread, var})
- DEPTH, 16, FIFO entries, power of two ≥ 2

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- IN_VALID  in  1  implication offered by unit-clause stage
- IN_READY  out  1  queue can accept this cycle
- IN_VAR  in  VAR_BITS  implied variable
- IN_VALUE  in  1  implied value
- IN_THREAD  in  1  solver thread tag
- OUT_EN  out  1  head literal valid to traversal engine
- OUT_READY  in  1  traversal engine consumes head
- OUT_VAR  out  VAR_BITS  head variable
- OUT_VALUE  out  1  head value
- OUT_THREAD  out  1  head thread
- FLUSH  in  1  backtrack: empty FIFO, clear table
- CONFLICT  out  1  sticky contradiction flag
- CONFLICT_VAR  out  VAR_BITS  variable that contradicted
- BUSY  out  1  table sweep in progress
- COUNT  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- FSM states are SWEEP, RUN and CONFLICT.
- SWEEP: one table entry is written UNASSIGNED per cycle, address 0 up to 2·2^VAR_BITS−1. After the last entry the FSM goes to RUN. IN_READY=0, OUT_EN=0, BUSY=1.
- RUN:
  - IN_READY = !full.
  - An accept is IN_VALID & IN_READY. On accept, the table is read combinationally at {IN_THREAD, IN_VAR}.
  - UNASSIGNED: the table entry is written with the value and the literal is pushed.
  - Same value: the literal is dropped; no push and no table change.
  - Opposite value: no push. CONFLICT and CONFLICT_VAR are set, and the FSM goes to CONFLICT.
- CONFLICT: IN_READY=0 and OUT_EN=0. FIFO contents are frozen. The state is left only by FLUSH.
- FLUSH (any state):
  - Takes priority over accept, pop and conflict in the same cycle.
  - Resets the FIFO pointers and COUNT to 0 and clears CONFLICT.
  - Enters SWEEP at address 0. FLUSH during SWEEP restarts the sweep.
- Reset enters SWEEP at address 0. The table memory itself has no reset.
- Pop: OUT_EN & OUT_READY, with OUT_EN = (state==RUN) & !empty. OUT_* show the FIFO head combinationally.
- Push and pop may occur in the same cycle when not full; COUNT is unchanged.
- Full: IN_READY=0. There is no bypass, even if a pop happens in the same cycle.

## Timing
- Reset values: IN_READY 0, OUT_EN 0, OUT_VAR 0, OUT_VALUE 0, OUT_THREAD 0, CONFLICT 0, CONFLICT_VAR 0, BUSY 1, COUNT 0.
- Sweep lasts 2·2^VAR_BITS cycles (128 at default). RUN starts on the following cycle.
- Latency: a literal accepted at edge N appears with OUT_EN=1 after edge N when the FIFO was empty.
- Table writes take effect at the accepting edge. A back-to-back accept of the same {thread,var} at edge N+1 sees the updated entry, so there is no hazard window.
- CONFLICT asserts after the accepting edge. OUT_EN drops on that same edge.
- Pointers wrap modulo DEPTH. COUNT ranges 0..DEPTH.

## Structure
- The shared package bcp_pkg holds:
  - typedef bcp_lit_t {thread, value, var}
  - the table-state enum: UNASSIGNED=2'b00, ASSIGNED_FALSE=2'b10, ASSIGNED_TRUE=2'b11
  - the FSM enum
- Sub-module bcp_fifo: synchronous FIFO of bcp_lit_t with push, pop, clear, full, empty and count.
- The assignment table and FSM live in bcp_imp_queue.

## Test plan
- Reset, then wait: BUSY=1 for exactly 128 cycles, then IN_READY=1, COUNT=0, OUT_EN=0.
- Push (T0, var 5, 1) with OUT_READY=0: the next cycle shows OUT_EN=1, OUT_VAR=5, OUT_VALUE=1, COUNT=1. Pulse OUT_READY and COUNT returns to 0.
- Push (T0, 5, 1) twice, back-to-back: COUNT=1, no conflict. Then push (T1, 5, 0): accepted, COUNT=2, since threads are independent.
- Push (T0, 7, 0), then (T0, 7, 1):
  - CONFLICT=1, CONFLICT_VAR=7, OUT_EN=0, IN_READY=0, COUNT held.
  - Then FLUSH: CONFLICT=0, COUNT=0, BUSY=1 for 128 cycles.
- With OUT_READY=0, push 16 distinct vars: IN_READY=0 at COUNT=16.
  - Pop and offer a push in the same cycle: the push is refused.
  - Next cycle the push is accepted; COUNT stays 16; FIFO order is preserved across wrap.
- Assert FLUSH in the same cycle as an accept that would conflict: the FLUSH wins, CONFLICT stays 0, and the FSM enters SWEEP.

Source files
------------

// File: rtl/bcp_imp_queue_pkg.sv
// Shared types for the BCP implication queue: literal struct, table encoding, FSM states.
package bcp_pkg;

  localparam int BCP_VAR_BITS = 6;

  typedef enum logic [1:0] {
    UNASSIGNED     = 2'b00,
    ASSIGNED_FALSE = 2'b10,
    ASSIGNED_TRUE  = 2'b11
  } tbl_st_e;

  typedef enum logic [1:0] {
    ST_SWEEP    = 2'b00,
    ST_RUN      = 2'b01,
    ST_CONFLICT = 2'b10
  } state_e;

  typedef struct packed {
    logic                    thread;
    logic                    value;
    logic [BCP_VAR_BITS-1:0] vr;
  } bcp_lit_t;

  function automatic tbl_st_e tbl_enc(input logic value);
    return value ? ASSIGNED_TRUE : ASSIGNED_FALSE;
  endfunction

endpackage

// File: rtl/bcp_imp_queue_fifo.sv
// Synchronous literal FIFO; clear wins over push/pop, pointers wrap modulo DEPTH.
module bcp_fifo
  import bcp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  bcp_lit_t      din,
  output bcp_lit_t      dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  bcp_lit_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_push = push & ~full & ~clear;
  assign w_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/bcp_imp_queue.sv
// Implication queue: filters implied literals against a per-thread assignment
// table, drops duplicates, flags contradictions, buffers new literals.
module bcp_imp_queue
  import bcp_pkg::*;
#(
  parameter int VAR_BITS = BCP_VAR_BITS,
  parameter int DEPTH    = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [VAR_BITS-1:0]        IN_VAR,
  input  logic                       IN_VALUE,
  input  logic                       IN_THREAD,
  output logic                       OUT_EN,
  input  logic                       OUT_READY,
  output logic [VAR_BITS-1:0]        OUT_VAR,
  output logic                       OUT_VALUE,
  output logic                       OUT_THREAD,
  input  logic                       FLUSH,
  output logic                       CONFLICT,
  output logic [VAR_BITS-1:0]        CONFLICT_VAR,
  output logic                       BUSY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int AW  = VAR_BITS + 1;
  localparam int TBL = 2 ** AW;

  state_e              r_state, w_state_nx;
  logic [AW-1:0]       r_sweep_addr, w_sweep_addr_nx;
  tbl_st_e             r_tbl [TBL];
  logic                r_conflict;
  logic [VAR_BITS-1:0] r_conflict_var;

  logic                w_full, w_empty;
  logic                w_accept, w_new, w_conf;
  logic [AW-1:0]       w_addr;
  tbl_st_e             w_ent;
  logic                w_tbl_we;
  logic [AW-1:0]       w_tbl_wa;
  tbl_st_e             w_tbl_wd;
  bcp_lit_t            w_din, w_head;

  assign w_addr   = {IN_THREAD, IN_VAR};
  assign w_ent    = r_tbl[w_addr];
  assign IN_READY = (r_state == ST_RUN) & ~w_full;
  assign w_accept = IN_VALID & IN_READY;
  assign w_new    = w_accept & (w_ent == UNASSIGNED);
  assign w_conf   = w_accept & (w_ent != UNASSIGNED) & (w_ent != tbl_enc(IN_VALUE));

  // Sweep owns the write port; in RUN only genuinely new literals update it.
  assign w_tbl_we = (r_state == ST_SWEEP) | (w_new & ~FLUSH);
  assign w_tbl_wa = (r_state == ST_SWEEP) ? r_sweep_addr : w_addr;
  assign w_tbl_wd = (r_state == ST_SWEEP) ? UNASSIGNED : tbl_enc(IN_VALUE);

  always_ff @(posedge CLK) begin
    if (w_tbl_we) r_tbl[w_tbl_wa] <= w_tbl_wd;
  end

  always_comb begin
    w_state_nx      = r_state;
    w_sweep_addr_nx = r_sweep_addr;
    case (r_state)
      ST_SWEEP: begin
        if (r_sweep_addr == '1) begin
          w_state_nx      = ST_RUN;
          w_sweep_addr_nx = '0;
        end else begin
          w_sweep_addr_nx = r_sweep_addr + 1'b1;
        end
      end
      ST_RUN:      if (w_conf) w_state_nx = ST_CONFLICT;
      ST_CONFLICT: w_state_nx = ST_CONFLICT;
      default:     w_state_nx = ST_SWEEP;
    endcase
    if (FLUSH) begin
      w_state_nx      = ST_SWEEP;
      w_sweep_addr_nx = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state        <= ST_SWEEP;
      r_sweep_addr   <= '0;
      r_conflict     <= 1'b0;
      r_conflict_var <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_sweep_addr <= w_sweep_addr_nx;
      if (FLUSH) begin
        r_conflict <= 1'b0;
      end else if (w_conf) begin
        r_conflict     <= 1'b1;
        r_conflict_var <= IN_VAR;
      end
    end
  end

  assign w_din = '{thread: IN_THREAD, value: IN_VALUE, vr: IN_VAR};

  bcp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (w_new & ~FLUSH),
    .pop   (OUT_EN & OUT_READY & ~FLUSH),
    .clear (FLUSH),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (COUNT)
  );

  // Head is masked while empty so outputs never expose uninitialised storage.
  assign OUT_EN       = (r_state == ST_RUN) & ~w_empty;
  assign OUT_VAR      = w_empty ? '0 : w_head.vr;
  assign OUT_VALUE    = ~w_empty & w_head.value;
  assign OUT_THREAD   = ~w_empty & w_head.thread;
  assign CONFLICT     = r_conflict;
  assign CONFLICT_VAR = r_conflict_var;
  assign BUSY         = (r_state == ST_SWEEP);

endmodule
